// File: rtl/lm_sm_sequencer_if.sv
// lm_sm_sequencer_if: LM/SM start/stall inputs and dual-slot micro-op outputs
interface lm_sm_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int MASK_W = 8
);
    logic              i_start_valid;
    logic              i_start_is_sm;
    logic [MASK_W-1:0] i_start_mask;
    logic [DATA_W-1:0] i_start_base;
    logic              i_hold;
    logic              i_flush;
    logic              o_busy;
    logic              o_uop1_valid;
    logic [2:0]        o_uop1_reg;
    logic [DATA_W-1:0] o_uop1_addr;
    logic              o_uop2_valid;
    logic [2:0]        o_uop2_reg;
    logic [DATA_W-1:0] o_uop2_addr;
    logic              o_uop_store;
    logic              o_done;
    modport master (
        output i_start_valid, i_start_is_sm, i_start_mask, i_start_base, i_hold, i_flush,
        input  o_busy, o_uop1_valid, o_uop1_reg, o_uop1_addr,
               o_uop2_valid, o_uop2_reg, o_uop2_addr, o_uop_store, o_done
    );
    modport slave (
        input  i_start_valid, i_start_is_sm, i_start_mask, i_start_base, i_hold, i_flush,
        output o_busy, o_uop1_valid, o_uop1_reg, o_uop1_addr,
               o_uop2_valid, o_uop2_reg, o_uop2_addr, o_uop_store, o_done
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: expands LM/SM into per-register micro-ops, two per cycle (one with LMSM_SINGLE_ISSUE_EN)
module lm_sm_sequencer #(
    parameter int DATA_W    = 16,
    parameter int MASK_W    = 8,
    parameter int ADDR_STEP = 2
) (
    input logic              i_clock,
    input logic              i_reset,
    lm_sm_sequencer_if.slave bus
);
`ifdef LMSM_SINGLE_ISSUE_EN
    localparam bit DUAL = 1'b0;
`else
    localparam bit DUAL = 1'b1;
`endif
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t            r_state;
    logic [MASK_W-1:0] r_mask;
    logic [DATA_W-1:0] r_base;
    logic [3:0]        r_k;
    logic              w_idle, w_v1, w_v2, w_go, w_store;
    logic [MASK_W-1:0] w_src, w_rem1, w_rem2;
    logic [DATA_W-1:0] w_base, w_a1, w_a2;
    logic [3:0]        w_k;
    logic [2:0]        w_r1, w_r2;
    // r_mask holds only the bits not yet presented, so an empty r_mask in ISSUE means the final pair is on the outputs
    always_comb begin
        w_idle  = r_state == IDLE;
        w_src   = w_idle ? bus.i_start_mask : r_mask;
        w_base  = w_idle ? bus.i_start_base : r_base;
        w_k     = w_idle ? 4'd0 : r_k;
        w_store = w_idle ? bus.i_start_is_sm : bus.o_uop_store;
        w_v1    = |w_src;
        w_rem1  = w_src & (w_src - MASK_W'(1));
        w_v2    = DUAL && |w_rem1;
        w_rem2  = w_v2 ? (w_rem1 & (w_rem1 - MASK_W'(1))) : w_rem1;
        w_r1    = '0;
        w_r2    = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (w_src[i]) w_r1 = 3'(i);
            if (w_rem1[i]) w_r2 = 3'(i);
        end
        w_a1 = w_base + DATA_W'(ADDR_STEP) * DATA_W'(w_k);
        w_a2 = w_a1 + DATA_W'(ADDR_STEP);
        w_go = w_idle ? (bus.i_start_valid && w_v1) : (r_state == ISSUE && w_v1);
    end
    always_ff @(posedge i_clock) begin
        if (i_reset || bus.i_flush || !bus.i_hold) begin
            r_state          <= IDLE;
            r_mask           <= '0;
            r_base           <= '0;
            r_k              <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_uop1_valid <= 1'b0;
            bus.o_uop1_reg   <= '0;
            bus.o_uop1_addr  <= '0;
            bus.o_uop2_valid <= 1'b0;
            bus.o_uop2_reg   <= '0;
            bus.o_uop2_addr  <= '0;
            bus.o_uop_store  <= 1'b0;
            bus.o_done       <= 1'b0;
            if (!i_reset && !bus.i_flush) begin
                if (w_go) begin
                    r_state          <= ISSUE;
                    r_mask           <= w_rem2;
                    r_base           <= w_base;
                    r_k              <= w_k + 4'(w_v1) + 4'(w_v2);
                    bus.o_busy       <= 1'b1;
                    bus.o_uop1_valid <= 1'b1;
                    bus.o_uop1_reg   <= w_r1;
                    bus.o_uop1_addr  <= w_a1;
                    bus.o_uop2_valid <= w_v2;
                    bus.o_uop2_reg   <= w_v2 ? w_r2 : '0;
                    bus.o_uop2_addr  <= w_v2 ? w_a2 : '0;
                    bus.o_uop_store  <= w_store;
                    bus.o_done       <= w_rem2 == '0;
                end else if (w_idle && bus.i_start_valid) begin
                    r_state         <= DONE;
                    bus.o_busy      <= 1'b1;
                    bus.o_uop_store <= w_store;
                    bus.o_done      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: table-driven, hand-written and randomized checks against a queue-based model
module tb_lm_sm_sequencer;
    localparam int DW = 16;
    localparam int MW = 8;
`ifdef LMSM_SINGLE_ISSUE_EN
    localparam bit DUAL = 1'b0;
`else
    localparam bit DUAL = 1'b1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    lm_sm_sequencer_if #(.DATA_W(DW), .MASK_W(MW)) bus ();
    lm_sm_sequencer #(.DATA_W(DW), .MASK_W(MW), .ADDR_STEP(2)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bus)
    );
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic        sm;
        logic [7:0]  mask;
        logic [15:0] base;
        int          len_d;
        int          len_s;
        logic [2:0]  r1;
        logic [15:0] a1;
        logic        v2;
        logic [2:0]  r2;
        logic [15:0] a2;
    } vec_t;
    vec_t tbl[5];
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", n, got, exp);
        end
    endtask
    task automatic expect_out(input string n, input logic busy, input logic v1, input logic [2:0] r1,
                              input logic [15:0] a1, input logic v2, input logic [2:0] r2,
                              input logic [15:0] a2, input logic st, input logic done);
        chk({n, " busy"}, 32'(bus.o_busy), 32'(busy));
        chk({n, " v1"}, 32'(bus.o_uop1_valid), 32'(v1));
        chk({n, " v2"}, 32'(bus.o_uop2_valid), 32'(v2));
        chk({n, " done"}, 32'(bus.o_done), 32'(done));
        if (busy) chk({n, " store"}, 32'(bus.o_uop_store), 32'(st));
        if (v1) begin
            chk({n, " r1"}, 32'(bus.o_uop1_reg), 32'(r1));
            chk({n, " a1"}, 32'(bus.o_uop1_addr), 32'(a1));
        end
        if (v2) begin
            chk({n, " r2"}, 32'(bus.o_uop2_reg), 32'(r2));
            chk({n, " a2"}, 32'(bus.o_uop2_addr), 32'(a2));
        end
    endtask
    task automatic start(input logic sm, input logic [7:0] mask, input logic [15:0] base);
        bus.i_start_valid = 1'b1;
        bus.i_start_is_sm = sm;
        bus.i_start_mask  = mask;
        bus.i_start_base  = base;
        tick();
        bus.i_start_valid = 1'b0;
    endtask
    // Model: registers to transfer form an ascending queue; each consumed cycle pops one or two of them
    task automatic run_seq(input logic sm, input logic [7:0] mask, input logic [15:0] base,
                           input int hold_pct, input int hold_first, input logic noise,
                           output int cyc, output logic [2:0] fr1, output logic [15:0] fa1,
                           output logic fv2, output logic [2:0] fr2, output logic [15:0] fa2);
        int q[$];
        int k, n, nh;
        logic h;
        logic [15:0] a;
        for (int i = 0; i < MW; i++) if (mask[i]) q.push_back(i);
        start(sm, mask, base);
        cyc = 0;
        k = 0;
        fr1 = '0; fa1 = '0; fv2 = 1'b0; fr2 = '0; fa2 = '0;
        do begin
            n = (DUAL && q.size() >= 2) ? 2 : (q.size() > 0 ? 1 : 0);
            a = base + 16'(2 * k);
            if (cyc == 0) begin
                fr1 = bus.o_uop1_reg; fa1 = bus.o_uop1_addr; fv2 = bus.o_uop2_valid;
                fr2 = bus.o_uop2_reg; fa2 = bus.o_uop2_addr;
            end
            nh = 0;
            do begin
                expect_out("seq", 1'b1, n > 0, (n > 0) ? 3'(q[0]) : 3'd0, a, n == 2,
                           (n == 2) ? 3'(q[1]) : 3'd0, a + 16'd2, sm, q.size() == n);
                h = (cyc == 0 && nh < hold_first) || (nh < 4 && $urandom_range(0, 99) < hold_pct);
                nh++;
                bus.i_hold = h;
                if (noise) begin
                    bus.i_start_valid = $urandom_range(0, 2) == 0;
                    bus.i_start_is_sm = ~sm;
                    bus.i_start_mask  = 8'($urandom);
                    bus.i_start_base  = 16'($urandom);
                end
                tick();
                bus.i_hold = 1'b0;
                bus.i_start_valid = 1'b0;
            end while (h);
            repeat (n) void'(q.pop_front());
            k += n;
            cyc++;
        end while (q.size() > 0);
        expect_out("idle", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
    endtask
    initial begin
        int cyc;
        logic [2:0] r1, r2;
        logic [15:0] a1, a2;
        logic v2;
        tbl[0] = '{1'b0, 8'hA5, 16'h0100, 2, 4, 3'd0, 16'h0100, 1'b1, 3'd2, 16'h0102};
        tbl[1] = '{1'b1, 8'h07, 16'h0040, 2, 3, 3'd0, 16'h0040, 1'b1, 3'd1, 16'h0042};
        tbl[2] = '{1'b0, 8'h00, 16'h1234, 1, 1, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000};
        tbl[3] = '{1'b0, 8'h03, 16'hFFFE, 1, 2, 3'd0, 16'hFFFE, 1'b1, 3'd1, 16'h0000};
        tbl[4] = '{1'b1, 8'h80, 16'h0010, 1, 1, 3'd7, 16'h0010, 1'b0, 3'd0, 16'h0000};
        bus.i_start_valid = 1'b0; bus.i_start_is_sm = 1'b0; bus.i_start_mask = '0;
        bus.i_start_base = '0; bus.i_hold = 1'b0; bus.i_flush = 1'b0;
        repeat (2) tick();
        expect_out("reset", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        chk("reset store", 32'(bus.o_uop_store), 32'd0);
        rst = 1'b0;
        tick();
        foreach (tbl[i]) begin
            run_seq(tbl[i].sm, tbl[i].mask, tbl[i].base, 0, 0, 1'b0, cyc, r1, a1, v2, r2, a2);
            chk($sformatf("tbl%0d len", i), 32'(cyc), 32'(DUAL ? tbl[i].len_d : tbl[i].len_s));
            chk($sformatf("tbl%0d v2", i), 32'(v2), 32'(tbl[i].v2 && DUAL));
            if (tbl[i].mask != 0) begin
                chk($sformatf("tbl%0d r1", i), 32'(r1), 32'(tbl[i].r1));
                chk($sformatf("tbl%0d a1", i), 32'(a1), 32'(tbl[i].a1));
            end
            if (tbl[i].v2 && DUAL) begin
                chk($sformatf("tbl%0d r2", i), 32'(r2), 32'(tbl[i].r2));
                chk($sformatf("tbl%0d a2", i), 32'(a2), 32'(tbl[i].a2));
            end
        end
        run_seq(1'b0, 8'hFF, 16'h2000, 0, 3, 1'b0, cyc, r1, a1, v2, r2, a2);
        chk("hold len", 32'(cyc), DUAL ? 32'd4 : 32'd8);
        run_seq(1'b1, 8'h5A, 16'h0300, 0, 0, 1'b1, cyc, r1, a1, v2, r2, a2);
        start(1'b0, 8'hFF, 16'h0500);
        tick();
        chk("flush pre r1", 32'(bus.o_uop1_reg), DUAL ? 32'd2 : 32'd1);
        bus.i_flush = 1'b1;
        bus.i_start_valid = 1'b1;
        bus.i_start_mask = 8'h0F;
        tick();
        bus.i_flush = 1'b0;
        bus.i_start_valid = 1'b0;
        expect_out("flush", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        run_seq(1'b1, 8'h0F, 16'h0600, 0, 0, 1'b0, cyc, r1, a1, v2, r2, a2);
        chk("post flush a1", 32'(a1), 32'h0600);
        start(1'b1, 8'hFF, 16'h0700);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("mid reset", 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
        chk("mid reset r1", 32'(bus.o_uop1_reg), 32'd0);
        chk("mid reset a1", 32'(bus.o_uop1_addr), 32'd0);
        chk("mid reset store", 32'(bus.o_uop_store), 32'd0);
        for (int i = 0; i < 40; i++) begin
            run_seq(1'($urandom), 8'($urandom), 16'($urandom), 25, 0, 1'b1, cyc, r1, a1, v2, r2, a2);
            if ($urandom_range(0, 1) == 1) tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
